// File: rtl/mapper_bit_slicer_pkg.sv
// Shared definitions for the mapper_mover stages: buffer geometry, slicer
// states and the bits-per-symbol clamp.
package mapper_pkg;

  localparam int unsigned BUF_W  = 64;
  localparam int unsigned FILL_W = 7;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    ST_STREAM,
    ST_FLUSH
  } slicer_state_e;

  // Out-of-range symbol widths fall back to the full table address width.
  function automatic logic [FILL_W-1:0] clamp_bps(input logic [2:0] bps,
                                                  input int unsigned max_bps);
    if (bps == 3'd0 || {29'd0, bps} > max_bps)
      return FILL_W'(max_bps);
    return FILL_W'(bps);
  endfunction

endpackage

// File: rtl/mapper_bit_slicer_if.sv
// Payload stream and mapper-table request bus of mapper_bit_slicer.
interface mapper_bit_slicer_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [31:0]       s_data;
  logic              s_last;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] t_addr;
  logic [31:0]       t_data;
  logic              t_we;
  logic              t_valid;
  logic              t_ready;

  modport slave (
    input  s_data, s_last, s_valid, t_ready,
    output s_ready, t_addr, t_data, t_we, t_valid
  );

  modport master (
    output s_data, s_last, s_valid, t_ready,
    input  s_ready, t_addr, t_data, t_we, t_valid
  );
endinterface

// File: rtl/mapper_bit_slicer_req_reg.sv
// mapper_req_reg: registered request output that holds its contents until the
// downstream table accepts them; reused by other mapper_mover stages.
module mapper_req_reg #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              t_valid,
  output logic              t_we,
  output logic [ADDR_W-1:0] t_addr,
  output logic [DATA_W-1:0] t_data,
  input  logic              t_ready
);

  assign in_ready = ~t_valid | t_ready;

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      t_valid <= 1'b0;
      t_we    <= 1'b0;
      t_addr  <= '0;
      t_data  <= '0;
    end else if (in_ready) begin
      t_valid <= in_valid;
      if (in_valid) begin
        t_we   <= in_we;
        t_addr <= in_addr;
        t_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mapper_bit_slicer.sv
// mapper_bit_slicer: slices a packed payload stream LSB-first into table
// addresses. Define MAPPER_SLICER_FLUSH_EN to zero-pad and emit frame residuals.
module mapper_bit_slicer
  import mapper_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic [2:0]        bps,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  mapper_bit_slicer_if.slave bus
);

  slicer_state_e     state_q, state_d;
  logic [BUF_W-1:0]  buf_q, buf_d, eff_buf;
  logic [FILL_W-1:0] fill_q, fill_d, eff_fill;
  logic [FILL_W-1:0] bps_q, bps_eff;
  logic              load_en, word_fire, cfg_fire, sym_fire, pad_fire, flush_done;
  logic              req_valid, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;

  assign bus.s_ready = rstf & (fill_q <= FILL_W'(WORD_W)) & (state_q == ST_STREAM);
  assign cfg_ready   = rstf & load_en;

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) state_q <= ST_STREAM;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STREAM: if (word_fire && bus.s_last) state_d = ST_FLUSH;
      ST_FLUSH:  if (flush_done) state_d = ST_STREAM;
    endcase
  end

  // The incoming word is merged before slicing so a word landing in an empty
  // buffer yields its first symbol on the accept edge.
  always_comb begin
    word_fire = bus.s_valid & bus.s_ready;
    cfg_fire  = cfg_valid & cfg_ready;
    bps_eff   = (fill_q == '0 && !bus.t_valid) ? clamp_bps(bps, ADDR_W) : bps_q;
    eff_buf   = buf_q;
    eff_fill  = fill_q;
    if (word_fire) begin
      eff_buf  = buf_q | (BUF_W'(bus.s_data) << fill_q);
      eff_fill = fill_q + FILL_W'(WORD_W);
    end
    sym_fire = load_en & ~cfg_fire & (eff_fill >= bps_eff);
`ifdef MAPPER_SLICER_FLUSH_EN
    pad_fire   = load_en & ~cfg_fire & (state_q == ST_FLUSH)
               & (eff_fill != '0) & (eff_fill < bps_eff);
    flush_done = (state_q == ST_FLUSH) & (fill_q < bps_eff) & ((fill_q == '0) | pad_fire);
`else
    pad_fire   = 1'b0;
    flush_done = (state_q == ST_FLUSH) & (fill_q < bps_eff);
`endif
    buf_d  = eff_buf;
    fill_d = eff_fill;
    if (sym_fire) begin
      buf_d  = eff_buf >> bps_eff;
      fill_d = eff_fill - bps_eff;
    end
    if (flush_done) begin
      buf_d  = '0;
      fill_d = '0;
    end
    req_valid = cfg_fire | sym_fire | pad_fire;
    req_we    = cfg_fire;
    req_addr  = cfg_fire ? cfg_addr
                         : ADDR_W'(eff_buf & ((BUF_W'(1) << bps_eff) - BUF_W'(1)));
    req_data  = cfg_fire ? cfg_data : '0;
  end

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      buf_q  <= '0;
      fill_q <= '0;
      bps_q  <= FILL_W'(ADDR_W);
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      bps_q  <= bps_eff;
    end
  end

  mapper_req_reg #(
    .ADDR_W(ADDR_W),
    .DATA_W(32)
  ) u_req_reg (
    .clk     (clk),
    .rstf    (rstf),
    .in_valid(req_valid),
    .in_we   (req_we),
    .in_addr (req_addr),
    .in_data (req_data),
    .in_ready(load_en),
    .t_valid (bus.t_valid),
    .t_we    (bus.t_we),
    .t_addr  (bus.t_addr),
    .t_data  (bus.t_data),
    .t_ready (bus.t_ready)
  );

endmodule
